board_renderer: RTL and testbench

- Pipelined, parametrised checkers-board pixel renderer for the VGA path.
- For each valid (x, y) pixel it returns one 24-bit colour, 3 cycles later.
- Colour covers the checkered board, filled player discs, king markers and a blinking cursor-square border.
- Board state is double-buffered. A new board is swapped in only at frame start, so the display never tears.

---
 rtl/board_renderer.sv | 180 ++++++++++++++++++
 tb/tb_board_renderer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_renderer.sv
// Three-stage checkers-board pixel renderer: board geometry, square/disc lookup, colour select.
// Board image is double-buffered and only swapped on frame_start to avoid tearing.
module board_renderer #(
   parameter int unsigned N            = 8,
   parameter int unsigned SQ           = 60,
   parameter int unsigned X_OFF        = 80,
   parameter int unsigned Y_OFF        = 0,
   parameter int unsigned RADIUS       = 25,
   parameter int unsigned BITS         = 4,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N*N*BITS-1:0]     board_in,
   input  logic                    board_load,
   input  logic                    frame_start,
   input  logic                    cursor_en,
   input  logic [$clog2(N)-1:0]    cursor_col,
   input  logic [$clog2(N)-1:0]    cursor_row,
   input  logic                    pix_valid_in,
   input  logic [9:0]              x,
   input  logic [8:0]              y,
   output logic                    pix_valid_out,
   output logic [7:0]              r,
   output logic [7:0]              g,
   output logic [7:0]              b,
   output logic                    load_pending
);

   localparam int unsigned CW   = $clog2(N);
   localparam int unsigned PW   = $clog2(SQ);
   localparam int unsigned HALF = SQ / 2;
   localparam int unsigned DW   = $clog2(2 * HALF * HALF + 1);
   localparam int unsigned FW   = $clog2(BLINK_FRAMES + 1);
   localparam int unsigned R2   = RADIUS * RADIUS;
   localparam int unsigned K2   = (RADIUS / 2) * (RADIUS / 2);
   localparam logic [10:0] XLO  = 11'(X_OFF);
   localparam logic [10:0] XHI  = 11'(X_OFF + N * SQ);
   localparam logic [10:0] YLO  = 11'(Y_OFF);
   localparam logic [10:0] YHI  = 11'(Y_OFF + N * SQ);

   logic [N*N*BITS-1:0] board_active, board_shadow;
   logic [FW-1:0]       frame_cnt;
   logic                blink;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         board_active <= '0;
         board_shadow <= '0;
         load_pending <= 1'b0;
         frame_cnt    <= '0;
         blink        <= 1'b1;
      end else begin
         // Swap uses the shadow as it was before any same-cycle load.
         if (frame_start && load_pending) board_active <= board_shadow;
         if (board_load) board_shadow <= board_in;
         if (board_load)       load_pending <= 1'b1;
         else if (frame_start) load_pending <= 1'b0;
         if (frame_start) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink     <= ~blink;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // Stage 1: board-relative coordinates
   logic [10:0] xe, ye, xr, yr;
   logic        in1;

   assign xe  = {1'b0, x};
   assign ye  = {2'b0, y};
   assign in1 = (xe >= XLO) && (xe < XHI) && (ye >= YLO) && (ye < YHI);
   assign xr  = in1 ? xe - XLO : '0;
   assign yr  = in1 ? ye - YLO : '0;

   logic          s1_valid, s1_inside;
   logic [CW-1:0] s1_col, s1_row;
   logic [PW-1:0] s1_px, s1_py;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_inside <= 1'b0;
         s1_col    <= '0;
         s1_row    <= '0;
         s1_px     <= '0;
         s1_py     <= '0;
      end else begin
         s1_valid  <= pix_valid_in;
         s1_inside <= in1;
         s1_col    <= CW'(xr / 11'(SQ));
         s1_row    <= CW'(yr / 11'(SQ));
         s1_px     <= PW'(xr % 11'(SQ));
         s1_py     <= PW'(yr % 11'(SQ));
      end
   end

   // Stage 2: square lookup, distance from square centre, cursor border
   logic [BITS-1:0]        sq1;
   logic                   unused_sq;
   logic signed [PW:0]     dx, dy;
   logic signed [2*PW+1:0] dxw, dyw, dxx, dyy;
   logic [DW-1:0]          d2_1;
   logic                   edge1, border1;

   always_comb begin
      sq1 = '0;
      for (int unsigned i = 0; i < N * N; i++) begin
         if (i == int'(s1_row) * N + int'(s1_col)) sq1 = board_active[i*BITS +: BITS];
      end
   end

   assign unused_sq = ^sq1;
   assign dx        = $signed({1'b0, s1_px}) - $signed((PW + 1)'(HALF));
   assign dy        = $signed({1'b0, s1_py}) - $signed((PW + 1)'(HALF));
   assign dxw       = dx;
   assign dyw       = dy;
   assign dxx       = dxw * dxw;
   assign dyy       = dyw * dyw;
   assign d2_1      = DW'($unsigned(dxx + dyy));
   assign edge1     = (s1_px < PW'(2)) || (s1_px >= PW'(SQ - 2)) ||
                      (s1_py < PW'(2)) || (s1_py >= PW'(SQ - 2));
   assign border1   = cursor_en && blink && (s1_col == cursor_col) &&
                      (s1_row == cursor_row) && edge1;

   logic          s2_valid, s2_inside, s2_occ, s2_red, s2_king, s2_border, s2_even;
   logic [DW-1:0] s2_d2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid  <= 1'b0;
         s2_inside <= 1'b0;
         s2_occ    <= 1'b0;
         s2_red    <= 1'b0;
         s2_king   <= 1'b0;
         s2_border <= 1'b0;
         s2_even   <= 1'b0;
         s2_d2     <= '0;
      end else begin
         s2_valid  <= s1_valid;
         s2_inside <= s1_inside;
         s2_occ    <= sq1[0];
         s2_red    <= sq1[1];
         s2_king   <= sq1[2];
         s2_border <= border1;
         s2_even   <= ~(s1_row[0] ^ s1_col[0]);
         s2_d2     <= d2_1;
      end
   end

   // Stage 3: colour priority
   logic [23:0] colour;

   always_comb begin
      colour = 24'h000000;
      if (!s2_inside)                                      colour = 24'h000000;
      else if (s2_border)                                  colour = 24'h0000FF;
      else if (s2_occ && s2_king && (32'(s2_d2) <= K2))    colour = 24'hFFD700;
      else if (s2_occ && (32'(s2_d2) <= R2))               colour = s2_red ? 24'hFF0000
                                                                           : 24'h00FF00;
      else if (s2_even)                                    colour = 24'hFFFFFF;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid_out <= 1'b0;
         r             <= '0;
         g             <= '0;
         b             <= '0;
      end else begin
         pix_valid_out <= s2_valid;
         if (s2_valid) {r, g, b} <= colour;
      end
   end

endmodule

// File: tb/tb_board_renderer.sv
// Randomised scoreboard bench for board_renderer against a frame-level reference model.
module tb_board_renderer;

   localparam int N = 8, SQ = 60, XO = 80, YO = 0, RAD = 25, BF = 30;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [255:0]    board_in = '0;
   logic            board_load = 1'b0, frame_start = 1'b0, cursor_en = 1'b0;
   logic [2:0]      cursor_col = '0, cursor_row = '0;
   logic            pix_valid_in = 1'b0;
   logic [9:0]      x = '0;
   logic [8:0]      y = '0;
   logic            pix_valid_out, load_pending;
   logic [7:0]      r, g, b;

   always #5 clk = ~clk;

   board_renderer #(
      .N(N), .SQ(SQ), .X_OFF(XO), .Y_OFF(YO), .RADIUS(RAD), .BITS(4), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .board_in(board_in), .board_load(board_load),
      .frame_start(frame_start), .cursor_en(cursor_en), .cursor_col(cursor_col),
      .cursor_row(cursor_row), .pix_valid_in(pix_valid_in), .x(x), .y(y),
      .pix_valid_out(pix_valid_out), .r(r), .g(g), .b(b), .load_pending(load_pending)
   );

   typedef struct {
      logic [23:0] col;
      int          due;
      int          px_x;
      int          px_y;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0, n_err = 0;

   // Reference model state
   logic [3:0] m_act[64], m_sh[64], m_new[64];
   bit         m_pend = 0;
   int         m_frames = 0;
   bit         m_cen = 0;
   int         m_ccol = 0, m_crow = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] ref_pix(int px_x, int px_y);
      int col, row, px, py, d2;
      logic [3:0] s;
      if (px_x < XO || px_x >= XO + N * SQ || px_y < YO || px_y >= YO + N * SQ) return 24'h000000;
      col = (px_x - XO) / SQ;
      px  = (px_x - XO) % SQ;
      row = (px_y - YO) / SQ;
      py  = (px_y - YO) % SQ;
      if (m_cen && ((m_frames / BF) % 2 == 0) && col == m_ccol && row == m_crow &&
          (px < 2 || px >= SQ - 2 || py < 2 || py >= SQ - 2)) return 24'h0000FF;
      s  = m_act[row * N + col];
      d2 = (px - SQ / 2) * (px - SQ / 2) + (py - SQ / 2) * (py - SQ / 2);
      if (s[0] && s[2] && d2 <= (RAD / 2) * (RAD / 2)) return 24'hFFD700;
      if (s[0] && d2 <= RAD * RAD) return s[1] ? 24'hFF0000 : 24'h00FF00;
      if ((row + col) % 2 == 0) return 24'hFFFFFF;
      return 24'h000000;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_act[i] = '0;
         m_sh[i]  = '0;
      end
      m_pend   = 0;
      m_frames = 0;
   endtask

   task automatic idle();
      @(negedge clk);
      pix_valid_in = 1'b0;
      board_load   = 1'b0;
      frame_start  = 1'b0;
   endtask

   task automatic drain();
      repeat (4) idle();
   endtask

   // use_exp selects a directed constant; otherwise the reference model supplies the colour.
   task automatic pix(int px_x, int px_y, bit use_exp, logic [23:0] e);
      exp_t t;
      @(negedge clk);
      board_load   = 1'b0;
      frame_start  = 1'b0;
      pix_valid_in = 1'b1;
      x            = 10'(px_x);
      y            = 9'(px_y);
      t.col  = use_exp ? e : ref_pix(px_x, px_y);
      t.due  = cyc + 3;
      t.px_x = px_x;
      t.px_y = px_y;
      q.push_back(t);
   endtask

   task automatic ctrl(bit ld, bit fs);
      @(negedge clk);
      pix_valid_in = 1'b0;
      board_load   = ld;
      frame_start  = fs;
      if (ld) for (int i = 0; i < 64; i++) board_in[i*4 +: 4] = m_new[i];
      if (fs && m_pend) m_act = m_sh;
      if (ld) m_sh = m_new;
      m_pend = ld ? 1'b1 : (fs ? 1'b0 : m_pend);
      if (fs) m_frames++;
      idle();
      check("load_pending", 32'(load_pending), 32'(m_pend));
   endtask

   task automatic set_cursor(bit en, int c, int rr);
      idle();
      cursor_en  = en;
      cursor_col = 3'(c);
      cursor_row = 3'(rr);
      m_cen  = en;
      m_ccol = c;
      m_crow = rr;
   endtask

   task automatic set_sq0(logic [3:0] v);
      for (int i = 0; i < 64; i++) m_new[i] = '0;
      m_new[0] = v;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a pixel
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) continue;
         if (pix_valid_out) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected pix_valid_out at cycle %0d", cyc);
            end else begin
               e = q.pop_front();
               n_vec++;
               if ({r, g, b} !== e.col || cyc != e.due) begin
                  n_err++;
                  $display("FAIL pixel (%0d,%0d): got %h at cycle %0d expected %h at cycle %0d",
                           e.px_x, e.px_y, {r, g, b}, cyc, e.col, e.due);
               end
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL pixel (%0d,%0d): pix_valid_out low at cycle %0d expected %h",
                     e.px_x, e.px_y, cyc, e.col);
         end
      end
   end

   initial begin
      model_reset();
      for (int i = 0; i < 64; i++) m_new[i] = '0;

      // Reset state
      #12;
      check("reset pix_valid_out", 32'(pix_valid_out), 32'd0);
      check("reset rgb", {8'd0, r, g, b}, 32'd0);
      check("reset load_pending", 32'(load_pending), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Empty board
      pix(110, 30, 1, 24'hFFFFFF);
      pix(170, 30, 1, 24'h000000);
      pix(50, 30, 1, 24'h000000);
      drain();

      // Cursor blink
      set_cursor(1, 1, 0);
      pix(141, 5, 1, 24'h0000FF);
      pix(170, 30, 1, 24'h000000);
      drain();
      repeat (30) ctrl(0, 1);
      pix(141, 5, 1, 24'h000000);
      pix(170, 30, 1, 24'h000000);
      drain();
      repeat (30) ctrl(0, 1);
      pix(141, 5, 1, 24'h0000FF);
      pix(170, 30, 1, 24'h000000);
      drain();
      set_cursor(0, 0, 0);

      // Load and swap
      set_sq0(4'b0011);
      ctrl(1, 0);
      pix(110, 30, 1, 24'hFFFFFF);
      drain();
      ctrl(0, 1);
      pix(110, 30, 1, 24'hFF0000);
      pix(110, 2, 1, 24'hFFFFFF);
      drain();

      // King
      set_sq0(4'b0111);
      ctrl(1, 0);
      ctrl(0, 1);
      pix(110, 30, 1, 24'hFFD700);
      pix(110, 45, 1, 24'hFF0000);
      drain();
      set_sq0(4'b0101);
      ctrl(1, 0);
      ctrl(0, 1);
      pix(110, 45, 1, 24'h00FF00);
      drain();

      // Simultaneous load and frame_start
      set_sq0(4'b0011);
      ctrl(1, 0);
      set_sq0(4'b0001);
      ctrl(1, 1);
      pix(110, 30, 1, 24'hFF0000);
      drain();
      ctrl(0, 1);
      pix(110, 30, 1, 24'h00FF00);
      drain();

      // Randomised boards, cursor and pixels
      for (int rnd = 0; rnd < 6; rnd++) begin
         for (int i = 0; i < 64; i++) m_new[i] = 4'($urandom_range(0, 15));
         ctrl(1, 0);
         ctrl(0, 1);
         repeat ($urandom_range(0, 35)) ctrl(0, 1);
         set_cursor(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)));
         repeat (40) begin
            if ($urandom_range(0, 3) == 0) idle();
            pix(int'($urandom_range(40, 620)), int'($urandom_range(0, 511)), 0, 24'h0);
         end
         drain();
      end
      set_cursor(0, 0, 0);

      // Reset with pixels in flight
      set_sq0(4'b0011);
      ctrl(1, 0);
      ctrl(0, 1);
      repeat (5) pix(110, 30, 1, 24'hFF0000);
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset pix_valid_out", 32'(pix_valid_out), 32'd0);
      check("midreset rgb", {8'd0, r, g, b}, 32'd0);
      q.delete();
      model_reset();
      idle();
      idle();
      @(negedge clk);
      reset_n = 1'b1;
      check("post-reset load_pending", 32'(load_pending), 32'd0);
      pix(110, 30, 1, 24'hFFFFFF);
      pix(110, 30, 0, 24'h0);
      drain();

      if (q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard: %0d pixels never returned, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
